time_set_ctrl: RTL

Sequencing controller for the clock's time-set and alarm-set datapath. Enabled by the top-level mode FSM (`set_time_en` or `set_alarm_en`), it walks the user through editing hours, then minutes, from the push buttons. It supports edge-triggered and auto-repeat increment with modulo wrap, and drives per-field blink flags for the display. When editing is finished it issues a one-cycle commit pulse and holds the `ack_flag` that the mode FSM needs before it leaves the mode.

---
 rtl/time_set_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// ============================================================================
// Module  : time_set_ctrl
// Purpose : hours/minutes edit sequencer with auto-repeat increment, field
//           blink and a commit/ack handshake back to the mode FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set_ctrl #(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4,
    parameter int BLINK_HALF   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode_button,
    input  logic       inc_button,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic [4:0] edit_hours,
    output logic [5:0] edit_minutes,
    output logic       ack_flag,
    output logic       commit,
    output logic       blink_hours,
    output logic       blink_minutes
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EDIT_H = 3'd2,
        EDIT_M = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] DELAY_CNT  = 8'(REPEAT_DELAY);
    // Reloading here puts the next hit exactly REPEAT_RATE cycles later.
    localparam logic [7:0] REARM_CNT  = 8'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

    state_t     state;
    state_t     state_n;
    logic       mode_q;
    logic       inc_q;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_n;
    logic [7:0] blink_cnt;
    logic [7:0] blink_cnt_n;
    logic       phase;
    logic       phase_n;
    logic [4:0] hours_n;
    logic [5:0] minutes_n;
    logic       mode_rise;
    logic       inc_rise;
    logic       in_edit;
    logic       repeat_hit;
    logic       inc_event;
    logic       state_change;

    always_comb begin
        mode_rise  = mode_button & ~mode_q;
        inc_rise   = inc_button & ~inc_q;
        in_edit    = (state == EDIT_H) || (state == EDIT_M);
        repeat_hit = inc_button && (hold_cnt == DELAY_CNT);
        inc_event  = in_edit && !mode_rise && (inc_rise || repeat_hit);

        state_n   = state;
        hours_n   = edit_hours;
        minutes_n = edit_minutes;

        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = LOAD;
                LOAD: begin
                    hours_n   = (cur_hours > 5'd23) ? 5'd0 : cur_hours;
                    minutes_n = (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                    state_n   = EDIT_H;
                end
                EDIT_H: begin
                    if (mode_rise) begin
                        state_n = EDIT_M;
                    end else if (inc_event) begin
                        hours_n = (edit_hours == 5'd23) ? 5'd0 : edit_hours + 5'd1;
                    end
                end
                EDIT_M: begin
                    if (mode_rise) begin
                        state_n = DONE;
                    end else if (inc_event) begin
                        minutes_n = (edit_minutes == 6'd59) ? 6'd0 : edit_minutes + 6'd1;
                    end
                end
                DONE: begin
                    if (inc_rise && !mode_rise) begin
                        state_n = EDIT_H;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        state_change = (state_n != state);

        // A zero count marks an idle hold counter, so a button still held
        // across a field change can never start auto-repeat.
        if (state_change || !in_edit || !inc_button) begin
            hold_cnt_n = 8'd0;
        end else if (inc_rise) begin
            hold_cnt_n = 8'd1;
        end else if (repeat_hit) begin
            hold_cnt_n = REARM_CNT;
        end else if (hold_cnt != 8'd0) begin
            hold_cnt_n = hold_cnt + 8'd1;
        end else begin
            hold_cnt_n = 8'd0;
        end

        phase_n     = phase;
        blink_cnt_n = blink_cnt;
        if (state_change || inc_event || !in_edit) begin
            phase_n     = 1'b0;
            blink_cnt_n = 8'd0;
        end else if (blink_cnt == BLINK_LAST) begin
            phase_n     = ~phase;
            blink_cnt_n = 8'd0;
        end else begin
            blink_cnt_n = blink_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mode_q        <= 1'b0;
            inc_q         <= 1'b0;
            hold_cnt      <= 8'd0;
            blink_cnt     <= 8'd0;
            phase         <= 1'b0;
            edit_hours    <= 5'd0;
            edit_minutes  <= 6'd0;
            ack_flag      <= 1'b0;
            commit        <= 1'b0;
            blink_hours   <= 1'b0;
            blink_minutes <= 1'b0;
        end else begin
            state         <= state_n;
            mode_q        <= mode_button;
            inc_q         <= inc_button;
            hold_cnt      <= hold_cnt_n;
            blink_cnt     <= blink_cnt_n;
            phase         <= phase_n;
            edit_hours    <= hours_n;
            edit_minutes  <= minutes_n;
            ack_flag      <= (state_n == DONE);
            commit        <= (state_n == DONE) && (state != DONE);
            blink_hours   <= phase_n && (state_n == EDIT_H);
            blink_minutes <= phase_n && (state_n == EDIT_M);
        end
    end

endmodule

`default_nettype wire
